// File: rtl/rm_seq_pkg.sv
// rm_seq_pkg
// Shared definitions for the runtime-monitor cluster sequencer:
//   - default parameter values for the sequencer and its report FIFO
//   - sequencer FSM state encoding
//   - report entry layout {vector, index} at the default widths
package rm_seq_pkg;

  localparam int SYM_W_DEF       = 8;
  localparam int NUM_REPORTS_DEF = 4;
  localparam int IDX_W_DEF       = 16;
  localparam int FIFO_DEPTH_DEF  = 8;
  localparam int RST_CYCLES_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [NUM_REPORTS_DEF-1:0] vector;
    logic [IDX_W_DEF-1:0]       index;
  } rpt_entry_t;

endpackage

// File: rtl/rm_report_fifo.sv
// rm_report_fifo
// Synchronous FIFO holding captured report entries.
// Ports:
//   clk, reset       - clock, asynchronous active-high reset (empties FIFO)
//   push, push_data  - write request and entry (ignored when full)
//   pop              - remove head entry (ignored when empty)
//   pop_data         - head entry, forced to zero while empty
//   full, empty      - occupancy flags
//   free_count       - number of unused entries
module rm_report_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign free_count = (AW+1)'(DEPTH) - count;
  assign do_push    = push & ~full;
  assign do_pop     = pop & ~empty;
  assign pop_data   = empty ? '0 : mem[rd_ptr];

  // Storage is not reset; the empty gate on pop_data hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rm_cluster_sequencer.sv
// rm_cluster_sequencer
// Sequences one runtime-monitor automaton cluster: holds it in reset between
// sessions, releases reset so the first symbol meets the cluster's
// start-of-data window, pulses ap_run once per accepted trace symbol, and
// queues non-zero report vectors tagged with their symbol index.
//
//   state | meaning
//   IDLE  | cluster held in reset, no symbols accepted
//   PRIME | cluster held in reset for RST_CYCLES, waiting for a symbol
//   RUN   | cluster released, symbols accepted while FIFO has room
//   DRAIN | one cycle to capture the report of the last symbol
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   start, stop           - session begin (IDLE only) / end (PRIME, RUN only)
//   sym_valid/ready/data  - trace symbol stream in
//   ap_reset, ap_run      - cluster reset and run strobes
//   ap_symbols            - symbol presented to the cluster
//   ap_report             - cluster report outputs (registered in cluster)
//   rpt_valid/ready       - report FIFO head handshake
//   rpt_vector, rpt_index - head entry contents
//   busy                  - session in progress (state != IDLE)
//   sym_count             - symbols accepted this session
module rm_cluster_sequencer
  import rm_seq_pkg::*;
#(
  parameter int SYM_W       = SYM_W_DEF,
  parameter int NUM_REPORTS = NUM_REPORTS_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sym_valid,
  output logic                   sym_ready,
  input  logic [SYM_W-1:0]       sym_data,
  output logic                   ap_reset,
  output logic                   ap_run,
  output logic [SYM_W-1:0]       ap_symbols,
  input  logic [NUM_REPORTS-1:0] ap_report,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [NUM_REPORTS-1:0] rpt_vector,
  output logic [IDX_W-1:0]       rpt_index,
  output logic                   busy,
  output logic [IDX_W-1:0]       sym_count
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES - 1);
  localparam int EW = NUM_REPORTS + IDX_W;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CW-1:0]    prime_cnt;
  logic             prime_done;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] idx_d;
  logic [SYM_W-1:0] sym_q;
  logic             acc_d;
  logic             accept;
  logic             room;
  logic [FW-1:0]    free_count;
  logic [FW-1:0]    room_need;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;

  // A report for the symbol accepted last cycle may still be on its way into
  // the FIFO, so reserve one extra entry for it on top of the two-entry margin.
  assign room_need  = acc_d ? FW'(3) : FW'(2);
  assign room       = (free_count >= room_need);
  assign prime_done = (prime_cnt == '0);

  assign sym_ready  = (state == RUN) & room & ~stop;
  assign accept     = sym_valid & sym_ready;
  assign ap_run     = accept;
  assign ap_symbols = accept ? sym_data : sym_q;
  assign ap_reset   = (state == IDLE) | (state == PRIME);
  assign busy       = (state != IDLE);
  assign sym_count  = index;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = PRIME;
      PRIME: begin
        if (stop) state_nxt = IDLE;
        else if (prime_done && sym_valid && room) state_nxt = RUN;
      end
      RUN:     if (stop) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prime_cnt <= '0;
      index     <= '0;
      idx_d     <= '0;
      sym_q     <= '0;
      acc_d     <= 1'b0;
    end else begin
      state <= state_nxt;
      acc_d <= accept;
      idx_d <= index;
      if (state == IDLE && start) begin
        prime_cnt <= CNT_LOAD;
        index     <= '0;
      end else if (state == PRIME && !prime_done) begin
        prime_cnt <= prime_cnt - CW'(1);
      end
      if (accept) begin
        index <= index + IDX_W'(1);
        sym_q <= sym_data;
      end
    end
  end

  // The cluster registers its report, so it lines up with the delayed accept.
  assign push = acc_d & (|ap_report) & ~fifo_full;
  assign pop  = rpt_valid & rpt_ready;

  rm_report_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_data  ({ap_report, idx_d}),
    .pop        (pop),
    .pop_data   (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .free_count (free_count)
  );

  assign rpt_valid               = ~fifo_empty;
  assign {rpt_vector, rpt_index} = head;

endmodule

// File: tb/tb_rm_cluster_sequencer.sv
module tb_rm_cluster_sequencer;

  import rm_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] sym_data;
  logic       ap_reset;
  logic       ap_run;
  logic [7:0] ap_symbols;
  logic [3:0] ap_report;
  logic       rpt_valid;
  logic       rpt_ready;
  logic [3:0] rpt_vector;
  logic [3:0] rpt_index;
  logic       busy;
  logic [3:0] sym_count;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] rpt_q[$];

  always #5 clk = ~clk;

  rm_cluster_sequencer #(
    .SYM_W       (8),
    .NUM_REPORTS (4),
    .IDX_W       (4),
    .FIFO_DEPTH  (8),
    .RST_CYCLES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .sym_data   (sym_data),
    .ap_reset   (ap_reset),
    .ap_run     (ap_run),
    .ap_symbols (ap_symbols),
    .ap_report  (ap_report),
    .rpt_valid  (rpt_valid),
    .rpt_ready  (rpt_ready),
    .rpt_vector (rpt_vector),
    .rpt_index  (rpt_index),
    .busy       (busy),
    .sym_count  (sym_count)
  );

  // Stub cluster: reports the low nibble of the symbol one cycle after ap_run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ap_report <= '0;
    else       ap_report <= ap_run ? ap_symbols[3:0] : 4'h0;
  end

  // Collector: records each entry popped from the report FIFO.
  always @(negedge clk) begin
    if (rpt_valid && rpt_ready) rpt_q.push_back({rpt_vector, rpt_index});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic end_session();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic send(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    sym_valid = 1'b1;
    sym_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (sym_ready) ok = 1'b1;
      step();
    end
    sym_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [7:0] exp_e;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    sym_valid = 1'b0; sym_data = 8'h00; rpt_ready = 1'b1;
    step(); step();

    // reset values
    check("rst_ap_reset", ap_reset, 1);
    check("rst_ap_run", ap_run, 0);
    check("rst_ap_symbols", ap_symbols, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_rpt_valid", rpt_valid, 0);
    check("rst_rpt_vector", rpt_vector, 0);
    check("rst_rpt_index", rpt_index, 0);
    check("rst_busy", busy, 0);
    check("rst_sym_count", sym_count, 0);
    reset = 1'b0;
    step();
    check("idle_sym_ready", sym_ready, 0);

    // basic run: 0x01, 0x00, 0x0A
    rpt_q.delete();
    pulse_start();
    check("basic_busy", busy, 1);
    send(8'h01);
    send(8'h00);
    send(8'h0A);
    repeat (5) step();
    check("basic_nrep", rpt_q.size(), 2);
    check("basic_rep0", rpt_q[0], 8'h10);
    check("basic_rep1", rpt_q[1], 8'hA2);
    check("basic_count", sym_count, 3);
    end_session();
    check("basic_idle", busy, 0);

    // priming: sym_valid held low for 5 cycles
    rpt_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prime_ap_reset", ap_reset, 1);
      check("prime_ap_run", ap_run, 0);
      step();
    end
    sym_valid = 1'b1;
    sym_data  = 8'h05;
    @(negedge clk);
    check("prime_exit_reset", ap_reset, 1);
    check("prime_exit_ready", sym_ready, 0);
    step();
    @(negedge clk);
    check("first_acc_reset", ap_reset, 0);
    check("first_acc_run", ap_run, 1);
    check("first_acc_sym", ap_symbols, 8'h05);
    step();
    sym_valid = 1'b0;
    step();

    // stop with a symbol offered in the same cycle
    sym_valid = 1'b1;
    sym_data  = 8'h03;
    stop      = 1'b1;
    @(negedge clk);
    check("stop_ready", sym_ready, 0);
    check("stop_run", ap_run, 0);
    check("stop_sym_hold", ap_symbols, 8'h05);
    step();
    stop      = 1'b0;
    sym_valid = 1'b0;
    @(negedge clk);
    check("drain_busy", busy, 1);
    check("drain_ap_reset", ap_reset, 0);
    check("drain_ready", sym_ready, 0);
    step();
    @(negedge clk);
    check("stop_idle_busy", busy, 0);
    check("stop_idle_reset", ap_reset, 1);
    check("stop_count", sym_count, 1);
    repeat (4) step();
    check("stop_nrep", rpt_q.size(), 1);
    check("stop_rep0", rpt_q[0], 8'h50);

    // backpressure: collector stalled, 0x0F streamed
    rpt_q.delete();
    rpt_ready = 1'b0;
    pulse_start();
    sym_valid = 1'b1;
    sym_data  = 8'h0F;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sym_valid && sym_ready) acc++;
      step();
    end
    check("bp_accepts", acc, 7);
    @(negedge clk);
    check("bp_ready_low", sym_ready, 0);
    check("bp_rpt_valid", rpt_valid, 1);
    step();
    sym_valid = 1'b0;
    rpt_ready = 1'b1;
    repeat (12) step();
    check("bp_nrep", rpt_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      exp_e = {4'hF, i[3:0]};
      check("bp_rep", rpt_q[i], exp_e);
    end
    end_session();

    // index wrap: 18 symbols of 0x01 with 4-bit index
    rpt_q.delete();
    pulse_start();
    sym_valid = 1'b1;
    sym_data  = 8'h01;
    acc = 0;
    for (int i = 0; i < 80 && acc < 18; i++) begin
      @(negedge clk);
      if (sym_valid && sym_ready) acc++;
      step();
      if (acc == 18) sym_valid = 1'b0;
    end
    sym_valid = 1'b0;
    check("wrap_accepts", acc, 18);
    repeat (6) step();
    check("wrap_nrep", rpt_q.size(), 18);
    for (int i = 0; i < 18; i++) begin
      exp_e = {4'h1, i[3:0]};
      check("wrap_rep", rpt_q[i], exp_e);
    end
    check("wrap_count", sym_count, 2);
    end_session();

    // asynchronous reset mid-RUN with FIFO occupied
    rpt_q.delete();
    rpt_ready = 1'b0;
    pulse_start();
    send(8'h07);
    send(8'h02);
    repeat (3) step();
    sym_valid = 1'b1;
    sym_data  = 8'h09;
    @(negedge clk);
    check("pre_rst_valid", rpt_valid, 1);
    check("pre_rst_run", ap_run, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ap_reset", ap_reset, 1);
    check("arst_ap_run", ap_run, 0);
    check("arst_ap_symbols", ap_symbols, 0);
    check("arst_sym_ready", sym_ready, 0);
    check("arst_rpt_valid", rpt_valid, 0);
    check("arst_rpt_vector", rpt_vector, 0);
    check("arst_rpt_index", rpt_index, 0);
    check("arst_busy", busy, 0);
    check("arst_sym_count", sym_count, 0);
    step();
    sym_valid = 1'b0;
    reset     = 1'b0;
    rpt_ready = 1'b1;
    repeat (4) step();
    check("arst_fifo_empty", rpt_valid, 0);
    check("arst_no_rep", rpt_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
